dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_fmt.sv | 43 ++++
 rtl/dmem_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and the request legality check for the data-memory controller.
// Mask encodings follow the load/store access-type field of the request port.
package dmem_pkg;

   typedef enum logic [2:0] {
      MASK_B  = 3'b000,
      MASK_H  = 3'b001,
      MASK_W  = 3'b010,
      MASK_BU = 3'b100,
      MASK_HU = 3'b101
   } mask_e;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      WAIT,
      RESP
   } state_e;

   // Misalignment, unknown encodings, unsigned stores and out-of-range words are rejected.
   function automatic logic req_error(mask_e mask, logic we, logic [1:0] lane,
                                      logic out_of_range);
      logic err;
      case (mask)
         MASK_B:  err = 1'b0;
         MASK_H:  err = lane[0];
         MASK_W:  err = (lane != 2'b00);
         MASK_BU: err = we;
         MASK_HU: err = we | lane[0];
         default: err = 1'b1;
      endcase
      return err | out_of_range;
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane handling: load extract with sign/zero extension, and the
// byte/halfword merge used by read-modify-write stores.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  mask_e       mask,
   input  logic [1:0]  lane,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      byte_sel   = word[{lane, 3'b000} +: 8];
      half_sel   = lane[1] ? word[31:16] : word[15:0];
      load_data  = '0;
      store_word = word;
      case (mask)
         MASK_B: begin
            load_data                       = {{24{byte_sel[7]}}, byte_sel};
            store_word[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         MASK_H: begin
            load_data = {{16{half_sel[15]}}, half_sel};
            if (lane[1]) store_word[31:16] = wdata[15:0];
            else         store_word[15:0]  = wdata[15:0];
         end
         MASK_W: begin
            load_data  = word;
            store_word = wdata;
         end
         MASK_BU: load_data = {24'h0, byte_sel};
         MASK_HU: load_data = {16'h0, half_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port word memory with a fill-on-reset sequencer and a one-outstanding
// request protocol; responses arrive a fixed RD_LAT cycles after acceptance.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LAT      = 1,
   parameter int INIT_MODE   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_mask,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_done
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_e          state;
   logic [AW-1:0]   fill_cnt;
   logic [1:0]      lat_cnt;
   logic            q_we;
   logic            q_err;
   mask_e           q_mask;
   logic [1:0]      q_lane;
   logic [AW-1:0]   q_idx;
   logic [31:0]     q_wdata;
   logic            wr_pend;
   logic [31:0]     rd_word;
   logic [31:0]     load_data;
   logic [31:0]     store_word;
   logic            accept;
   logic            acc_err;
   logic [AW-1:0]   acc_idx;
   logic [31:0]     mem [DEPTH_WORDS];

   assign accept  = req_valid & req_ready;
   assign acc_idx = req_addr[AW+1:2];
   assign acc_err = req_error(mask_e'(req_mask), req_we, req_addr[1:0],
                              |req_addr[31:AW+2]);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= INIT;
         fill_cnt  <= '0;
         lat_cnt   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         init_done <= 1'b0;
         wr_pend   <= 1'b0;
         q_we      <= 1'b0;
         q_err     <= 1'b0;
         q_mask    <= MASK_B;
         q_lane    <= '0;
         q_idx     <= '0;
         q_wdata   <= '0;
      end else begin
         wr_pend <= 1'b0;
         case (state)
            INIT: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == AW'(DEPTH_WORDS - 1)) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end
            end
            IDLE: begin
               if (accept) begin
                  q_we      <= req_we;
                  q_err     <= acc_err;
                  q_mask    <= mask_e'(req_mask);
                  q_lane    <= req_addr[1:0];
                  q_idx     <= acc_idx;
                  q_wdata   <= req_wdata;
                  wr_pend   <= req_we & ~acc_err;
                  req_ready <= 1'b0;
                  if (RD_LAT > 1) begin
                     state   <= WAIT;
                     lat_cnt <= 2'(RD_LAT - 2);
                  end else begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (lat_cnt == 2'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

   // NOTE: the array has no reset; its contents come only from the INIT fill sequence.
   always_ff @(posedge clk) begin
      if (state == INIT)
         mem[fill_cnt] <= (INIT_MODE != 0) ? 32'(fill_cnt) : 32'h0;
      else if (wr_pend)
         mem[q_idx] <= store_word;
      if (accept)
         rd_word <= mem[acc_idx];
   end

   dmem_lane_fmt u_lane_fmt (
      .word       (rd_word),
      .wdata      (q_wdata),
      .mask       (q_mask),
      .lane       (q_lane),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // Stores and rejected requests report zero data.
   assign rsp_rdata = (rsp_valid & ~q_err & ~q_we) ? load_data : 32'h0;
   assign rsp_err   = rsp_valid & q_err;

endmodule
